mem_dispatch_que: RTL and testbench

Multi-port in-order buffer between rename/dispatch and the load queue. It accepts up to INPORT_NUM memory micro-ops per cycle, compacts sparse request masks into consecutive slots, and presents up to OUTPORT_NUM oldest entries per cycle as a contiguous group to the load queue's enqueue port. It decouples rename bandwidth from load-queue back-pressure and is cleared on pipeline flush.

---
 rtl/mem_dispatch_que_pkg.sv | 20 ++
 rtl/count_one.sv | 23 ++
 rtl/mem_dispatch_que_req_compact.sv | 28 ++
 rtl/mem_dispatch_que.sv | 144 ++++++++++++++
 tb/tb_mem_dispatch_que.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dispatch_que_pkg.sv
// -----------------------------------------------------------------------------
// mem_dispatch_que_pkg
// Shared types and default sizing for the memory dispatch queue.
//   memDQEntry_t : payload carried from rename/dispatch into the load queue.
//   MDQ_*        : default port counts and depth used by the top level.
// -----------------------------------------------------------------------------
package mem_dispatch_que_pkg;

    localparam int MDQ_INPORT_NUM  = 4;
    localparam int MDQ_OUTPORT_NUM = 4;
    localparam int MDQ_DEPTH       = 16;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [3:0]  lq_idx;
        logic [3:0]  mem_op;
        logic [31:0] imm;
    } memDQEntry_t;

endpackage

// File: rtl/count_one.sv
// -----------------------------------------------------------------------------
// count_one
// Combinational population count.
//   vec : input bit vector
//   cnt : number of set bits in vec
// -----------------------------------------------------------------------------
module count_one #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    // Sum all bits of the vector.
    always_comb begin
        cnt = {CNT_W{1'b0}};
        for (int k = 0; k < WIDTH; k++) begin
            cnt = cnt + CNT_W'(vec[k]);
        end
    end

endmodule

// File: rtl/mem_dispatch_que_req_compact.sv
// -----------------------------------------------------------------------------
// req_compact
// Maps a sparse request mask to dense slot offsets: offset[k] is the number of
// set request bits below port k, so the k-th active port lands at tail+offset.
//   req    : per-port request mask
//   offset : per-port slot offset (exclusive prefix popcount)
// -----------------------------------------------------------------------------
module req_compact #(
    parameter int N     = 4,
    parameter int OFS_W = $clog2(N + 1)
) (
    input  logic [N-1:0]            req,
    output logic [N-1:0][OFS_W-1:0] offset
);

    logic [OFS_W-1:0] acc_s;

    // Exclusive prefix sum of the request bits in ascending port order.
    always_comb begin
        acc_s  = {OFS_W{1'b0}};
        offset = '0;
        for (int k = 0; k < N; k++) begin
            offset[k] = acc_s;
            acc_s     = acc_s + OFS_W'(req[k]);
        end
    end

endmodule

// File: rtl/mem_dispatch_que.sv
// -----------------------------------------------------------------------------
// mem_dispatch_que
// In-order multi-port buffer between rename/dispatch and the load queue.
// Sparse enqueue masks are compacted into consecutive slots; up to OUTPORT_NUM
// oldest entries are presented each cycle as a contiguous group.
//   clk, rst     : clock, asynchronous active-high reset
//   i_flush      : synchronous clear of all entries
//   o_can_enq    : whole request group fits in the free space
//   i_enq_vld    : enqueue group valid
//   i_enq_req    : per-port request mask (may be sparse)
//   i_enq_data   : per-port payload
//   o_deq_vld    : at least one entry presented
//   o_deq_req    : contiguous-from-bit-0 valid mask
//   o_deq_data   : oldest entries, slot 0 oldest
//   i_can_deq    : downstream takes the entire presented group
// -----------------------------------------------------------------------------
module mem_dispatch_que
    import mem_dispatch_que_pkg::*;
#(
    parameter int INPORT_NUM  = MDQ_INPORT_NUM,
    parameter int OUTPORT_NUM = MDQ_OUTPORT_NUM,
    parameter int DEPTH       = MDQ_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_flush,
    output logic                               o_can_enq,
    input  logic                               i_enq_vld,
    input  logic        [INPORT_NUM-1:0]       i_enq_req,
    input  memDQEntry_t [INPORT_NUM-1:0]       i_enq_data,
    output logic                               o_deq_vld,
    output logic        [OUTPORT_NUM-1:0]      o_deq_req,
    output memDQEntry_t [OUTPORT_NUM-1:0]      o_deq_data,
    input  logic                               i_can_deq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OFS_W = $clog2(INPORT_NUM + 1);

    // Slot arithmetic is done one bit wider, then folded back by one DEPTH.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [IDX_W-1:0] sum);
        logic [IDX_W-1:0] adj;
        if (sum >= IDX_W'(DEPTH)) begin
            adj = sum - IDX_W'(DEPTH);
        end else begin
            adj = sum;
        end
        return adj[PTR_W-1:0];
    endfunction

    memDQEntry_t                      buff_r [DEPTH];
    logic [PTR_W-1:0]                 head_r;
    logic [PTR_W-1:0]                 tail_r;
    logic [CNT_W-1:0]                 count_r;

    logic [OFS_W-1:0]                 enq_num_s;
    logic [INPORT_NUM-1:0][OFS_W-1:0] enq_ofs_s;
    logic [CNT_W-1:0]                 free_s;
    logic [CNT_W-1:0]                 deq_n_s;
    logic                             enq_fire_s;
    logic                             deq_fire_s;

    count_one #(
        .WIDTH (INPORT_NUM),
        .CNT_W (OFS_W)
    ) u_enq_cnt (
        .vec (i_enq_req),
        .cnt (enq_num_s)
    );

    req_compact #(
        .N     (INPORT_NUM),
        .OFS_W (OFS_W)
    ) u_req_compact (
        .req    (i_enq_req),
        .offset (enq_ofs_s)
    );

    // Space check uses the registered count only, so a same-cycle pop never
    // makes room for the incoming group.
    always_comb begin
        free_s     = CNT_W'(DEPTH) - count_r;
        o_can_enq  = (CNT_W'(enq_num_s) <= free_s);
        enq_fire_s = i_enq_vld && o_can_enq && !i_flush;
    end

    // Presented group size and mask depend only on registered count, which
    // keeps the load queue's can_enq out of any combinational loop.
    always_comb begin
        if (count_r < CNT_W'(OUTPORT_NUM)) begin
            deq_n_s = count_r;
        end else begin
            deq_n_s = CNT_W'(OUTPORT_NUM);
        end
        for (int k = 0; k < OUTPORT_NUM; k++) begin
            o_deq_req[k] = (CNT_W'(k) < deq_n_s);
        end
        o_deq_vld  = (deq_n_s != {CNT_W{1'b0}});
        deq_fire_s = o_deq_vld && i_can_deq && !i_flush;
    end

    // Read mux: oldest entries starting at head; slots beyond the group are
    // don't-care and simply show whatever is stored there.
    always_comb begin
        for (int k = 0; k < OUTPORT_NUM; k++) begin
            o_deq_data[k] = buff_r[wrap_idx(IDX_W'(head_r) + IDX_W'(k))];
        end
    end

    // Payload write: each active port goes to tail plus its compacted offset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < INPORT_NUM; k++) begin
            if (enq_fire_s && i_enq_req[k]) begin
                buff_r[wrap_idx(IDX_W'(tail_r) + IDX_W'(enq_ofs_s[k]))] <= i_enq_data[k];
            end
        end
    end

    // Pointer and occupancy registers; reset and flush both empty the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_fire_s) begin
                tail_r <= wrap_idx(IDX_W'(tail_r) + IDX_W'(enq_num_s));
            end
            if (deq_fire_s) begin
                head_r <= wrap_idx(IDX_W'(head_r) + IDX_W'(deq_n_s));
            end
            count_r <= count_r
                     + (enq_fire_s ? CNT_W'(enq_num_s) : {CNT_W{1'b0}})
                     - (deq_fire_s ? deq_n_s : {CNT_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_mem_dispatch_que.sv
// -----------------------------------------------------------------------------
// tb_mem_dispatch_que
// Self-checking bench: a queue-based reference model tracks the expected
// contents; each scenario task compares DUT outputs against it inline.
// -----------------------------------------------------------------------------
module tb_mem_dispatch_que;
    import mem_dispatch_que_pkg::*;

    localparam int NIN   = 4;
    localparam int NOUT  = 4;
    localparam int DEPTH = 16;

    logic                         clk;
    logic                         rst;
    logic                         i_flush;
    logic                         o_can_enq;
    logic                         i_enq_vld;
    logic        [NIN-1:0]        i_enq_req;
    memDQEntry_t [NIN-1:0]        i_enq_data;
    logic                         o_deq_vld;
    logic        [NOUT-1:0]       o_deq_req;
    memDQEntry_t [NOUT-1:0]       o_deq_data;
    logic                         i_can_deq;

    int n_checks;
    int n_fail;

    memDQEntry_t mq[$];

    mem_dispatch_que dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .o_can_enq  (o_can_enq),
        .i_enq_vld  (i_enq_vld),
        .i_enq_req  (i_enq_req),
        .i_enq_data (i_enq_data),
        .o_deq_vld  (o_deq_vld),
        .o_deq_req  (o_deq_req),
        .o_deq_data (o_deq_data),
        .i_can_deq  (i_can_deq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic memDQEntry_t rand_entry();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[$bits(memDQEntry_t)-1:0];
    endfunction

    function automatic int popc(input logic [NIN-1:0] m);
        int c = 0;
        for (int k = 0; k < NIN; k++) c += int'(m[k]);
        return c;
    endfunction

    function automatic int exp_n();
        return (mq.size() < NOUT) ? mq.size() : NOUT;
    endfunction

    function automatic logic [NOUT-1:0] exp_mask();
        int n = exp_n();
        logic [NOUT-1:0] m = '0;
        for (int k = 0; k < NOUT; k++) if (k < n) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_can_enq();
        return popc(i_enq_req) <= (DEPTH - mq.size());
    endfunction

    task automatic fill_inputs(input logic vld, input logic [NIN-1:0] req, input logic cdq);
        i_enq_vld = vld;
        i_enq_req = req;
        i_can_deq = cdq;
        for (int k = 0; k < NIN; k++) i_enq_data[k] = rand_entry();
    endtask

    // Advance one clock and update the model from the inputs held over the edge.
    task automatic tick();
        int  sz;
        int  nn;
        bit  ef;
        bit  df;
        sz = mq.size();
        nn = (sz < NOUT) ? sz : NOUT;
        ef = i_enq_vld && (popc(i_enq_req) <= DEPTH - sz) && !i_flush;
        df = (sz > 0) && i_can_deq && !i_flush;
        @(posedge clk);
        #1;
        if (i_flush) begin
            mq.delete();
        end else begin
            if (df) repeat (nn) void'(mq.pop_front());
            if (ef) for (int k = 0; k < NIN; k++) if (i_enq_req[k]) mq.push_back(i_enq_data[k]);
        end
    endtask

    task automatic do_flush();
        fill_inputs(1'b0, 4'b0000, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_flush = 1'b0;
        fill_inputs(1'b0, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_deq_vld !== 1'b0) begin n_fail++; $display("FAIL reset_deq_vld got %b want 0", o_deq_vld); end
        n_checks++;
        if (o_deq_req !== 4'b0000) begin n_fail++; $display("FAIL reset_deq_req got %b want 0000", o_deq_req); end
        n_checks++;
        if (o_can_enq !== 1'b1) begin n_fail++; $display("FAIL reset_can_enq got %b want 1", o_can_enq); end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
    endtask

    task automatic test_sparse();
        memDQEntry_t a;
        memDQEntry_t c;
        fill_inputs(1'b1, 4'b1010, 1'b0);
        a = i_enq_data[1];
        c = i_enq_data[3];
        #1;
        n_checks++;
        if (o_can_enq !== 1'b1) begin n_fail++; $display("FAIL sparse_can_enq got %b want 1", o_can_enq); end
        tick();
        fill_inputs(1'b0, 4'b0000, 1'b0);
        #1;
        n_checks++;
        if (o_deq_req !== 4'b0011) begin n_fail++; $display("FAIL sparse_deq_req got %b want 0011", o_deq_req); end
        n_checks++;
        if (o_deq_data[0] !== a) begin n_fail++; $display("FAIL sparse_data0 got %h want %h", o_deq_data[0], a); end
        n_checks++;
        if (o_deq_data[1] !== c) begin n_fail++; $display("FAIL sparse_data1 got %h want %h", o_deq_data[1], c); end
    endtask

    task automatic test_full();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            fill_inputs(1'b1, 4'b1111, 1'b0);
            #1;
            n_checks++;
            if (o_can_enq !== 1'b1) begin n_fail++; $display("FAIL fill_can_enq[%0d] got %b want 1", i, o_can_enq); end
            tick();
        end
        fill_inputs(1'b1, 4'b0001, 1'b0);
        #1;
        n_checks++;
        if (o_can_enq !== 1'b0) begin n_fail++; $display("FAIL full_can_enq got %b want 0", o_can_enq); end
        tick();
        #1;
        n_checks++;
        if (o_can_enq !== 1'b0 || o_deq_req !== 4'b1111) begin
            n_fail++; $display("FAIL full_hold got can_enq=%b req=%b want 0/1111", o_can_enq, o_deq_req);
        end
        i_can_deq = 1'b1;
        #1;
        n_checks++;
        if (o_can_enq !== 1'b0) begin n_fail++; $display("FAIL full_pop_can_enq got %b want 0", o_can_enq); end
        tick();
        i_can_deq = 1'b0;
        #1;
        n_checks++;
        if (mq.size() != 12 || o_can_enq !== 1'b1) begin
            n_fail++; $display("FAIL after_pop_can_enq got %b want 1 (model size %0d want 12)", o_can_enq, mq.size());
        end
        for (int k = 0; k < NOUT; k++) begin
            n_checks++;
            if (o_deq_data[k] !== mq[k]) begin n_fail++; $display("FAIL after_pop_data%0d got %h want %h", k, o_deq_data[k], mq[k]); end
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        for (int c = 0; c < 11; c++) begin
            fill_inputs(1'b1, 4'b1111, 1'b1);
            #1;
            if (c > 0) begin
                n_checks++;
                if (o_deq_req !== 4'b1111 || o_can_enq !== 1'b1) begin
                    n_fail++; $display("FAIL stream_ctl[%0d] got req=%b can_enq=%b want 1111/1", c, o_deq_req, o_can_enq);
                end
                for (int k = 0; k < NOUT; k++) begin
                    n_checks++;
                    if (o_deq_data[k] !== mq[k]) begin n_fail++; $display("FAIL stream_data[%0d][%0d] got %h want %h", c, k, o_deq_data[k], mq[k]); end
                end
            end
            tick();
        end
        fill_inputs(1'b0, 4'b0000, 1'b0);
        #1;
        n_checks++;
        if (o_deq_req !== 4'b1111) begin n_fail++; $display("FAIL stream_end_req got %b want 1111", o_deq_req); end
    endtask

    task automatic test_partial_pop();
        do_flush();
        fill_inputs(1'b1, 4'b0111, 1'b0);
        tick();
        fill_inputs(1'b1, 4'b1111, 1'b1);
        #1;
        n_checks++;
        if (o_deq_req !== 4'b0111 || o_can_enq !== 1'b1) begin
            n_fail++; $display("FAIL partial_pre got req=%b can_enq=%b want 0111/1", o_deq_req, o_can_enq);
        end
        tick();
        fill_inputs(1'b0, 4'b0000, 1'b0);
        #1;
        n_checks++;
        if (o_deq_req !== 4'b1111) begin n_fail++; $display("FAIL partial_post_req got %b want 1111", o_deq_req); end
        for (int k = 0; k < NOUT; k++) begin
            n_checks++;
            if (o_deq_data[k] !== mq[k]) begin n_fail++; $display("FAIL partial_data%0d got %h want %h", k, o_deq_data[k], mq[k]); end
        end
    endtask

    task automatic test_flush();
        do_flush();
        fill_inputs(1'b1, 4'b1111, 1'b0); tick();
        fill_inputs(1'b1, 4'b1111, 1'b0); tick();
        fill_inputs(1'b1, 4'b0001, 1'b0); tick();
        fill_inputs(1'b1, 4'b1111, 1'b1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        fill_inputs(1'b0, 4'b1111, 1'b0);
        #1;
        n_checks++;
        if (o_deq_vld !== 1'b0 || o_deq_req !== 4'b0000) begin
            n_fail++; $display("FAIL flush_deq got vld=%b req=%b want 0/0000", o_deq_vld, o_deq_req);
        end
        n_checks++;
        if (o_can_enq !== 1'b1) begin n_fail++; $display("FAIL flush_can_enq got %b want 1", o_can_enq); end
    endtask

    task automatic test_async_reset();
        memDQEntry_t x;
        do_flush();
        fill_inputs(1'b1, 4'b1111, 1'b0); tick();
        fill_inputs(1'b1, 4'b0001, 1'b0); tick();
        fill_inputs(1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_deq_vld !== 1'b0 || o_deq_req !== 4'b0000) begin
            n_fail++; $display("FAIL async_rst got vld=%b req=%b want 0/0000", o_deq_vld, o_deq_req);
        end
        mq.delete();
        #4;
        rst = 1'b0;
        fill_inputs(1'b1, 4'b0100, 1'b0);
        x = i_enq_data[2];
        tick();
        fill_inputs(1'b0, 4'b0000, 1'b0);
        #1;
        n_checks++;
        if (dut.buff_r[0] !== x) begin n_fail++; $display("FAIL rst_slot0 got %h want %h", dut.buff_r[0], x); end
        n_checks++;
        if (o_deq_req !== 4'b0001 || o_deq_data[0] !== x) begin
            n_fail++; $display("FAIL rst_first got req=%b data=%h want 0001/%h", o_deq_req, o_deq_data[0], x);
        end
    endtask

    task automatic test_random();
        do_flush();
        for (int c = 0; c < 400; c++) begin
            fill_inputs($urandom_range(0, 3) != 0, 4'($urandom),
                        (c < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0));
            i_flush = ($urandom_range(0, 40) == 0);
            #1;
            n_checks++;
            if (o_can_enq !== exp_can_enq()) begin n_fail++; $display("FAIL rnd_can_enq[%0d] got %b want %b", c, o_can_enq, exp_can_enq()); end
            n_checks++;
            if (o_deq_req !== exp_mask() || o_deq_vld !== (exp_n() != 0)) begin
                n_fail++; $display("FAIL rnd_deq[%0d] got req=%b vld=%b want %b/%b", c, o_deq_req, o_deq_vld, exp_mask(), exp_n() != 0);
            end
            for (int k = 0; k < exp_n(); k++) begin
                n_checks++;
                if (o_deq_data[k] !== mq[k]) begin n_fail++; $display("FAIL rnd_data[%0d][%0d] got %h want %h", c, k, o_deq_data[k], mq[k]); end
            end
            tick();
            i_flush = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sparse();
        test_full();
        test_back_to_back();
        test_partial_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
